// File: rtl/apb_pkg.sv
// apb_pkg
// Shared definitions for the APB memory slave: FSM state encoding, wait
// counter width and the byte-strobe width helper.
package apb_pkg;

  // Wait-state counter width; covers WAIT_CYC up to 15.
  localparam int CNT_BW = 4;

  // state   | meaning
  // ST_IDLE | no transfer in progress, waiting for a setup phase
  // ST_WAIT | transfer latched, counting down wait states
  // ST_DONE | pready=1 this cycle, write commits / read data presented
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Number of byte lanes for a given data width.
  function automatic int strb_bw(input int data_bw);
    return data_bw / 8;
  endfunction

endpackage

// File: rtl/apb_mem_array.sv
// apb_mem_array
// DEPTH x DATA_BW word storage with per-byte write enables and a registered
// read port. Contents are not reset; only the read register is.
// Ports:
//   i_clk, i_rst    clock, async active-high reset (read register only)
//   i_wr_be         per-byte write enables, all-zero means no write
//   i_wr_addr/data  write word address and data
//   i_rd_en         load the read register this cycle
//   i_rd_zero       load zero instead of the addressed word
//   i_rd_addr       read word address
//   o_rd_data       registered read data, holds between loads
module apb_mem_array
  import apb_pkg::*;
#(
  parameter int DATA_BW = 32,
  parameter int DEPTH   = 64,
  parameter int AW      = 6
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic [strb_bw(DATA_BW)-1:0] i_wr_be,
  input  logic [AW-1:0]               i_wr_addr,
  input  logic [DATA_BW-1:0]          i_wr_data,
  input  logic                        i_rd_en,
  input  logic                        i_rd_zero,
  input  logic [AW-1:0]               i_rd_addr,
  output logic [DATA_BW-1:0]          o_rd_data
);

  localparam int STRB_BW = strb_bw(DATA_BW);

  logic [DATA_BW-1:0] r_mem [DEPTH];
  logic [DATA_BW-1:0] r_rd_data;

  always_ff @(posedge i_clk) begin
    for (int b = 0; b < STRB_BW; b++) begin
      if (i_wr_be[b]) begin
        r_mem[i_wr_addr][8*b +: 8] <= i_wr_data[8*b +: 8];
      end
    end
  end

  // i_rd_zero guards out-of-range addresses so r_mem is never indexed past DEPTH.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rd_data <= '0;
    end else if (i_rd_en) begin
      r_rd_data <= i_rd_zero ? '0 : r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/apb_mem_slave.sv
// apb_mem_slave
// APB4 memory slave with byte strobes, WAIT_CYC wait states, registered
// outputs and pslverr on word addresses >= DEPTH.
// Ports:
//   i_clk, i_rst            clock, async active-high reset
//   i_psel, i_penable       APB select / access phase
//   i_pwrite, i_paddr       direction, word address
//   i_pwdata, i_pstrb       write data, byte strobes (ignored on reads)
//   o_prdata                read data, meaningful with o_pready on reads
//   o_pready, o_pslverr     transfer complete, error response
module apb_mem_slave
  import apb_pkg::*;
#(
  parameter int DATA_BW  = 32,
  parameter int ADDR_BW  = 8,
  parameter int DEPTH    = 64,
  parameter int WAIT_CYC = 2
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_psel,
  input  logic                        i_penable,
  input  logic                        i_pwrite,
  input  logic [ADDR_BW-1:0]          i_paddr,
  input  logic [DATA_BW-1:0]          i_pwdata,
  input  logic [strb_bw(DATA_BW)-1:0] i_pstrb,
  output logic [DATA_BW-1:0]          o_prdata,
  output logic                        o_pready,
  output logic                        o_pslverr
);

  localparam int STRB_BW = strb_bw(DATA_BW);
  localparam int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_BW:0]    DEPTH_V  = (ADDR_BW+1)'(DEPTH);
  localparam logic [CNT_BW-1:0]   CNT_LOAD = (WAIT_CYC > 0) ? CNT_BW'(WAIT_CYC - 1) : '0;

  state_t               r_state, w_next;
  logic [CNT_BW-1:0]    r_cnt;
  logic [ADDR_BW-1:0]   r_addr;
  logic                 r_write;
  logic [DATA_BW-1:0]   r_wdata;
  logic [STRB_BW-1:0]   r_strb;
  logic                 r_err;
  logic                 r_pready;
  logic                 r_pslverr;

  logic                 w_setup;
  logic [ADDR_BW-1:0]   w_addr_cur;
  logic                 w_write_cur;
  logic                 w_err_cur;
  logic                 w_rd_en;
  logic [STRB_BW-1:0]   w_wr_be;

  assign w_setup = i_psel & ~i_penable;

  // With WAIT_CYC=0, DONE is entered on the setup edge itself, before the
  // latches hold the transfer, so the live bus is used while still in IDLE.
  assign w_addr_cur  = (r_state == ST_IDLE) ? i_paddr  : r_addr;
  assign w_write_cur = (r_state == ST_IDLE) ? i_pwrite : r_write;
  assign w_err_cur   = ({1'b0, w_addr_cur} >= DEPTH_V);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_setup) w_next = (WAIT_CYC == 0) ? ST_DONE : ST_WAIT;
      ST_WAIT: begin
        if (!i_psel)         w_next = ST_IDLE;
        else if (r_cnt == '0) w_next = ST_DONE;
      end
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt     <= '0;
      r_addr    <= '0;
      r_write   <= 1'b0;
      r_wdata   <= '0;
      r_strb    <= '0;
      r_err     <= 1'b0;
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
    end else begin
      if (r_state == ST_IDLE && w_setup) begin
        r_addr  <= i_paddr;
        r_write <= i_pwrite;
        r_wdata <= i_pwdata;
        r_strb  <= i_pstrb;
        r_err   <= ({1'b0, i_paddr} >= DEPTH_V);
        r_cnt   <= CNT_LOAD;
      end else if (r_state == ST_WAIT && r_cnt != '0) begin
        r_cnt <= r_cnt - 1'b1;
      end
      r_pready  <= (w_next == ST_DONE);
      r_pslverr <= (w_next == ST_DONE) && w_err_cur;
    end
  end

  // Read data is captured on the edge that enters DONE.
  assign w_rd_en = (w_next == ST_DONE) && !w_write_cur;
  assign w_wr_be = (r_state == ST_DONE && r_write && !r_err) ? r_strb : '0;

  apb_mem_array #(
    .DATA_BW (DATA_BW),
    .DEPTH   (DEPTH),
    .AW      (AW)
  ) u_mem (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_wr_be   (w_wr_be),
    .i_wr_addr (r_addr[AW-1:0]),
    .i_wr_data (r_wdata),
    .i_rd_en   (w_rd_en),
    .i_rd_zero (w_err_cur),
    .i_rd_addr (w_addr_cur[AW-1:0]),
    .o_rd_data (o_prdata)
  );

  assign o_pready  = r_pready;
  assign o_pslverr = r_pslverr;

endmodule

// File: tb/tb_apb_mem_slave.sv
// tb_apb_mem_slave
// Two slaves (WAIT_CYC=2 and WAIT_CYC=0) share one APB master; use0 selects
// which one is addressed. Expected responses are queued at issue time and
// popped by a monitor whenever pready is seen.
module tb_apb_mem_slave;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        m_psel, m_penable, m_pwrite;
  logic [7:0]  m_paddr;
  logic [31:0] m_pwdata;
  logic [3:0]  m_pstrb;
  logic        use0;

  logic [31:0] prdata2, prdata0, prdata;
  logic        pready2, pready0, pready;
  logic        pslverr2, pslverr0, pslverr;
  logic        psel2, psel0;

  assign psel2   = m_psel & ~use0;
  assign psel0   = m_psel & use0;
  assign prdata  = use0 ? prdata0  : prdata2;
  assign pready  = use0 ? pready0  : pready2;
  assign pslverr = use0 ? pslverr0 : pslverr2;

  apb_mem_slave #(.DATA_BW(32), .ADDR_BW(8), .DEPTH(64), .WAIT_CYC(2)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_psel(psel2), .i_penable(m_penable),
    .i_pwrite(m_pwrite), .i_paddr(m_paddr), .i_pwdata(m_pwdata), .i_pstrb(m_pstrb),
    .o_prdata(prdata2), .o_pready(pready2), .o_pslverr(pslverr2));

  apb_mem_slave #(.DATA_BW(32), .ADDR_BW(8), .DEPTH(64), .WAIT_CYC(0)) u_dut0 (
    .i_clk(clk), .i_rst(rst), .i_psel(psel0), .i_penable(m_penable),
    .i_pwrite(m_pwrite), .i_paddr(m_paddr), .i_pwdata(m_pwdata), .i_pstrb(m_pstrb),
    .o_prdata(prdata0), .o_pready(pready0), .o_pslverr(pslverr0));

  typedef struct {
    bit          rd;
    logic [31:0] data;
    bit          err;
  } exp_t;

  exp_t        q[$];
  exp_t        me;
  logic [31:0] mem2 [64];
  logic [31:0] mem0 [64];
  int          checks = 0;
  int          errors = 0;

  function automatic int wcyc();
    return use0 ? 0 : 2;
  endfunction

  function automatic logic [31:0] model_read(input logic [7:0] a);
    if (a >= 8'd64) return 32'h0;
    return use0 ? mem0[a[5:0]] : mem2[a[5:0]];
  endfunction

  task automatic model_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] w;
    if (a >= 8'd64) return;
    w = use0 ? mem0[a[5:0]] : mem2[a[5:0]];
    for (int b = 0; b < 4; b++) if (s[b]) w[8*b +: 8] = d[8*b +: 8];
    if (use0) mem0[a[5:0]] = w;
    else      mem2[a[5:0]] = w;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic xfer(input bit wr, input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
    exp_t e;
    int   acc;
    e.rd   = !wr;
    e.err  = (a >= 8'd64);
    e.data = wr ? 32'h0 : model_read(a);
    q.push_back(e);
    if (wr) model_write(a, d, s);
    m_psel = 1'b1; m_penable = 1'b0; m_pwrite = wr;
    m_paddr = a; m_pwdata = d; m_pstrb = s;
    @(posedge clk); #1 m_penable = 1'b1;
    acc = 1;
    forever begin
      @(negedge clk);
      if (pready || acc >= 20) break;
      acc++;
    end
    checks++;
    if (!pready) begin
      errors++;
      $display("FAIL timeout addr %h: no pready after %0d access cycles", a, acc);
      if (q.size() > 0) void'(q.pop_back());
    end else if (acc != wcyc() + 1) begin
      errors++;
      $display("FAIL latency addr %h got %0d access cycles expected %0d", a, acc, wcyc() + 1);
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    m_psel = 1'b0; m_penable = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Transfer abandoned (psel dropped) k cycles into the access phase.
  task automatic abort_xfer(input logic [7:0] a, input logic [31:0] d, input int k);
    m_psel = 1'b1; m_penable = 1'b0; m_pwrite = 1'b1;
    m_paddr = a; m_pwdata = d; m_pstrb = 4'hF;
    @(posedge clk); #1 m_penable = 1'b1;
    repeat (k) @(posedge clk);
    #1 m_psel = 1'b0; m_penable = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst && pready) begin
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_pready got pready=1 expected no transfer pending");
      end else begin
        me = q.pop_front();
        checks++;
        if (pslverr !== me.err) begin
          errors++;
          $display("FAIL pslverr addr %h got %b expected %b", m_paddr, pslverr, me.err);
        end
        if (me.rd) begin
          checks++;
          if (prdata !== me.data) begin
            errors++;
            $display("FAIL prdata addr %h got %h expected %h", m_paddr, prdata, me.data);
          end
        end
      end
    end else if (!rst && !pready) begin
      checks++;
      if (pslverr !== 1'b0) begin
        errors++;
        $display("FAIL pslverr_idle got %b expected 0", pslverr);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; use0 = 1'b0;
    m_psel = 1'b0; m_penable = 1'b0; m_pwrite = 1'b0;
    m_paddr = '0; m_pwdata = '0; m_pstrb = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pready2",  {31'b0, pready2},  32'h0);
    chk("rst_pslverr2", {31'b0, pslverr2}, 32'h0);
    chk("rst_prdata2",  prdata2,           32'h0);
    chk("rst_pready0",  {31'b0, pready0},  32'h0);
    chk("rst_pslverr0", {31'b0, pslverr0}, 32'h0);
    chk("rst_prdata0",  prdata0,           32'h0);
    rst = 1'b0;
    idle(2);

    // WAIT_CYC=2 slave
    for (int i = 0; i < 64; i++) xfer(1'b1, 8'(i), $urandom, 4'hF);
    idle(1);
    xfer(1'b1, 8'h05, 32'hDEADBEEF, 4'hF); idle(1);
    xfer(1'b0, 8'h05, 32'h0, 4'h0);         idle(1);
    xfer(1'b1, 8'h05, 32'h11223344, 4'h5); idle(1);
    xfer(1'b0, 8'h05, 32'h0, 4'hF);         idle(1);
    chk("model_strobe_merge", model_read(8'h05), 32'hDE22BE44);
    xfer(1'b1, 8'h40, 32'h12345678, 4'hF);
    xfer(1'b0, 8'h40, 32'h0, 4'h0);
    xfer(1'b0, 8'h00, 32'h0, 4'h0);
    idle(1);
    abort_xfer(8'h07, 32'hCAFEF00D, 1); idle(2);
    xfer(1'b0, 8'h07, 32'h0, 4'h0); idle(1);
    xfer(1'b1, 8'h05, 32'hFFFFFFFF, 4'h0); idle(1);
    xfer(1'b0, 8'h05, 32'h0, 4'h0); idle(1);

    // reset in WAIT of a write to 0x09
    m_psel = 1'b1; m_penable = 1'b0; m_pwrite = 1'b1;
    m_paddr = 8'h09; m_pwdata = 32'hA5A5A5A5; m_pstrb = 4'hF;
    @(posedge clk); #1 m_penable = 1'b1;
    rst = 1'b1;
    #1;
    chk("midrst_pready",  {31'b0, pready2},  32'h0);
    chk("midrst_pslverr", {31'b0, pslverr2}, 32'h0);
    chk("midrst_prdata",  prdata2,           32'h0);
    @(posedge clk); #1 rst = 1'b0;
    idle(1);
    xfer(1'b0, 8'h09, 32'h0, 4'h0); idle(1);

    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        abort_xfer(8'($urandom_range(0, 79)), $urandom, int'($urandom_range(0, 1)));
        idle(1);
      end else begin
        xfer(1'($urandom_range(0, 1)), 8'($urandom_range(0, 79)), $urandom, 4'($urandom_range(0, 15)));
        if ($urandom_range(0, 2) == 0) idle(1);
      end
    end
    idle(3);

    // WAIT_CYC=0 slave, back-to-back
    use0 = 1'b1;
    idle(1);
    for (int i = 0; i < 64; i++) xfer(1'b1, 8'(i), $urandom, 4'hF);
    xfer(1'b1, 8'h0A, 32'h0BADF00D, 4'hF);
    xfer(1'b0, 8'h0A, 32'h0, 4'h0);
    xfer(1'b1, 8'h3F, 32'h76543210, 4'hF);
    xfer(1'b0, 8'h3F, 32'h0, 4'h0);
    xfer(1'b0, 8'h40, 32'h0, 4'h0);
    for (int i = 0; i < 80; i++) begin
      xfer(1'($urandom_range(0, 1)), 8'($urandom_range(0, 79)), $urandom, 4'($urandom_range(0, 15)));
      if ($urandom_range(0, 4) == 0) idle(1);
    end
    idle(5);

    chk("queue_drained", 32'(q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
